// File: rtl/write_port_arbiter.sv
// write_port_arbiter
//   Arbitrates two byte-stream burst requesters (load and drain) onto a
//   single register-file write port. A requester presents a burst
//   descriptor (target register, write mode, byte count); once granted it
//   owns the port until its byte count is exhausted and the final write
//   has drained, so bursts never interleave.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ld_burst_req/addr/mode/len   load burst descriptor request
//   ld_burst_gnt             1-cycle pulse: load descriptor latched
//   ld_data/ld_valid/ld_ready    load byte stream (accepted on valid&&ready)
//   ld_done                  1-cycle pulse at load burst completion
//   dr_*                     drain-requester equivalents
//   wr_req/addr/mode/data    register-file write strobe and payload
//   wr_busy                  register file cannot take a byte this cycle
//   owner, arb_busy          current owner (00 idle, 01 load, 10 drain)
//
// Configuration
//   WRITE_ARB_DRAIN_PRIORITY_EN  when defined, a simultaneous request in
//   IDLE always grants drain; otherwise round-robin with load winning the
//   first tie after reset.

package vTPU_pkg;
    localparam int NUM_REGS = 16;
endpackage

module write_port_arbiter #(
    parameter int  NUM_REGS = vTPU_pkg::NUM_REGS,
    parameter int  LEN_W    = 8,
    localparam int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             ld_burst_req,
    input  logic [AW-1:0]    ld_burst_addr,
    input  logic [1:0]       ld_burst_mode,
    input  logic [LEN_W-1:0] ld_burst_len,
    output logic             ld_burst_gnt,
    input  logic [7:0]       ld_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    output logic             ld_done,

    input  logic             dr_burst_req,
    input  logic [AW-1:0]    dr_burst_addr,
    input  logic [1:0]       dr_burst_mode,
    input  logic [LEN_W-1:0] dr_burst_len,
    output logic             dr_burst_gnt,
    input  logic [7:0]       dr_data,
    input  logic             dr_valid,
    output logic             dr_ready,
    output logic             dr_done,

    output logic             wr_req,
    output logic [AW-1:0]    wr_addr,
    output logic [1:0]       wr_mode,
    output logic [7:0]       wr_data,
    input  logic             wr_busy,

    output logic [1:0]       owner,
    output logic             arb_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [1:0]     OWN_NONE = 2'b00;
    localparam logic [1:0]     OWN_LD   = 2'b01;
    localparam logic [1:0]     OWN_DR   = 2'b10;
    localparam logic [LEN_W:0] CNT_ONE  = (LEN_W + 1)'(1);

    // A zero length field encodes a full 2^LEN_W byte burst.
    function automatic logic [LEN_W:0] burst_count(input logic [LEN_W-1:0] len);
        burst_count = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    endfunction

    state_t           state_q,     state_d;
    logic [1:0]       owner_q,     owner_d;
    logic [LEN_W:0]   cnt_q,       cnt_d;
    logic [AW-1:0]    desc_addr_q, desc_addr_d;
    logic [1:0]       desc_mode_q, desc_mode_d;
    logic             wr_req_q,    wr_req_d;
    logic [AW-1:0]    wr_addr_q,   wr_addr_d;
    logic [1:0]       wr_mode_q,   wr_mode_d;
    logic [7:0]       wr_data_q,   wr_data_d;
`ifndef WRITE_ARB_DRAIN_PRIORITY_EN
    logic             last_dr_q,   last_dr_d;   // 1: drain was granted last
`endif

    logic pick_ld, pick_dr;
    logic grant_ok, flush_ok;
    logic ld_acc, dr_acc, byte_acc;
    logic [7:0] byte_in;

    // Tie-break between simultaneous requests.
    always_comb begin
`ifdef WRITE_ARB_DRAIN_PRIORITY_EN
        pick_dr = dr_burst_req;
        pick_ld = ld_burst_req && !dr_burst_req;
`else
        pick_ld = ld_burst_req && (!dr_burst_req ||  last_dr_q);
        pick_dr = dr_burst_req && (!ld_burst_req || !last_dr_q);
`endif
    end

    // Grant, ready and done are decoded from the registered state so that
    // they land in the same cycle as the condition that causes them; rst
    // masks them so every output reads 0 while reset is applied.
    assign grant_ok     = !rst && (state_q == IDLE);
    assign ld_burst_gnt = grant_ok && pick_ld;
    assign dr_burst_gnt = grant_ok && pick_dr;

    assign ld_ready = !rst && (state_q == LOAD)  && !wr_busy;
    assign dr_ready = !rst && (state_q == DRAIN) && !wr_busy;
    assign ld_acc   = ld_ready && ld_valid;
    assign dr_acc   = dr_ready && dr_valid;
    assign byte_acc = ld_acc || dr_acc;
    assign byte_in  = (state_q == LOAD) ? ld_data : dr_data;

    // FLUSH completes once the last write strobe has been issued and the
    // register file is no longer busy.
    assign flush_ok = !rst && (state_q == FLUSH) && !wr_req_q && !wr_busy;
    assign ld_done  = flush_ok && (owner_q == OWN_LD);
    assign dr_done  = flush_ok && (owner_q == OWN_DR);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        desc_addr_d = desc_addr_q;
        desc_mode_d = desc_mode_q;
        wr_req_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_mode_d   = wr_mode_q;
        wr_data_d   = wr_data_q;
`ifndef WRITE_ARB_DRAIN_PRIORITY_EN
        last_dr_d   = last_dr_q;
`endif

        case (state_q)
            IDLE: begin
                if (ld_burst_gnt) begin
                    state_d     = LOAD;
                    owner_d     = OWN_LD;
                    cnt_d       = burst_count(ld_burst_len);
                    desc_addr_d = ld_burst_addr;
                    desc_mode_d = ld_burst_mode;
`ifndef WRITE_ARB_DRAIN_PRIORITY_EN
                    last_dr_d   = 1'b0;
`endif
                end else if (dr_burst_gnt) begin
                    state_d     = DRAIN;
                    owner_d     = OWN_DR;
                    cnt_d       = burst_count(dr_burst_len);
                    desc_addr_d = dr_burst_addr;
                    desc_mode_d = dr_burst_mode;
`ifndef WRITE_ARB_DRAIN_PRIORITY_EN
                    last_dr_d   = 1'b1;
`endif
                end
            end

            // Both transfer states share one datapath; byte_in selects the
            // owner's stream.
            LOAD, DRAIN: begin
                if (byte_acc) begin
                    wr_req_d  = 1'b1;
                    wr_addr_d = desc_addr_q;
                    wr_mode_d = desc_mode_q;
                    wr_data_d = byte_in;
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = FLUSH;
                    end
                end
            end

            FLUSH: begin
                if (flush_ok) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= '0;
            desc_addr_q <= '0;
            desc_mode_q <= '0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_mode_q   <= '0;
            wr_data_q   <= '0;
`ifndef WRITE_ARB_DRAIN_PRIORITY_EN
            last_dr_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            desc_addr_q <= desc_addr_d;
            desc_mode_q <= desc_mode_d;
            wr_req_q    <= wr_req_d;
            wr_addr_q   <= wr_addr_d;
            wr_mode_q   <= wr_mode_d;
            wr_data_q   <= wr_data_d;
`ifndef WRITE_ARB_DRAIN_PRIORITY_EN
            last_dr_q   <= last_dr_d;
`endif
        end
    end

    assign wr_req   = wr_req_q;
    assign wr_addr  = wr_addr_q;
    assign wr_mode  = wr_mode_q;
    assign wr_data  = wr_data_q;
    assign owner    = owner_q;
    assign arb_busy = (owner_q != OWN_NONE);

endmodule

// File: tb/tb_write_port_arbiter.sv
// Testbench for write_port_arbiter: a directed vector table for the basic
// load burst and a reset-abort, hand-written sequences for ties, wr_busy
// stalls, 256-byte bursts and overlapping requests, then randomized traffic
// checked cycle by cycle against a transaction-level reference model.

module tb_write_port_arbiter;

    localparam int NUM_REGS = vTPU_pkg::NUM_REGS;
    localparam int LEN_W    = 8;
    localparam int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef WRITE_ARB_DRAIN_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             ld_burst_req, dr_burst_req;
    logic [AW-1:0]    ld_burst_addr, dr_burst_addr;
    logic [1:0]       ld_burst_mode, dr_burst_mode;
    logic [LEN_W-1:0] ld_burst_len, dr_burst_len;
    logic             ld_burst_gnt, dr_burst_gnt;
    logic [7:0]       ld_data, dr_data;
    logic             ld_valid, dr_valid, ld_ready, dr_ready, ld_done, dr_done;
    logic             wr_req, wr_busy, arb_busy;
    logic [AW-1:0]    wr_addr;
    logic [1:0]       wr_mode, owner;
    logic [7:0]       wr_data;

    write_port_arbiter #(.NUM_REGS(NUM_REGS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .ld_burst_req(ld_burst_req), .ld_burst_addr(ld_burst_addr),
        .ld_burst_mode(ld_burst_mode), .ld_burst_len(ld_burst_len),
        .ld_burst_gnt(ld_burst_gnt), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .dr_burst_req(dr_burst_req), .dr_burst_addr(dr_burst_addr),
        .dr_burst_mode(dr_burst_mode), .dr_burst_len(dr_burst_len),
        .dr_burst_gnt(dr_burst_gnt), .dr_data(dr_data), .dr_valid(dr_valid),
        .dr_ready(dr_ready), .dr_done(dr_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_mode(wr_mode),
        .wr_data(wr_data), .wr_busy(wr_busy),
        .owner(owner), .arb_busy(arb_busy)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: who owns the port, bytes still owed, whether the
    // burst is draining its final write, and the write-port register image.
    int m_owner = 0;      // 0 none, 1 load, 2 drain
    bit m_flush = 0;
    int m_left  = 0;
    int m_addr  = 0, m_mode = 0;
    int m_last  = 2;      // requester granted most recently
    bit m_wr    = 0;
    int m_waddr = 0, m_wmode = 0, m_wdata = 0;
    bit model_chk = 0;
    bit auto_data = 0;

    // Per-cycle samples and event bookkeeping.
    logic s_ld_gnt, s_dr_gnt, s_ld_ready, s_dr_ready, s_ld_done, s_dr_done;
    logic s_wr_req, s_busy;
    logic [AW-1:0] s_wr_addr;
    logic [1:0] s_wr_mode, s_owner;
    logic [7:0] s_wr_data;
    int n_wr = 0, n_ldd = 0, n_drd = 0, n_drg = 0;
    int grants[$];
    int gnt_cyc[$];
    int done_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        int win;
        bit e_lr, e_dr, e_ldn, e_ddn, acc;
        @(negedge clk);
        win = 0;
        if (!rst && m_owner == 0) begin
            if (ld_burst_req && dr_burst_req) win = PRIO ? 2 : ((m_last == 1) ? 2 : 1);
            else if (ld_burst_req) win = 1;
            else if (dr_burst_req) win = 2;
        end
        e_lr  = !rst && m_owner == 1 && !m_flush && !wr_busy;
        e_dr  = !rst && m_owner == 2 && !m_flush && !wr_busy;
        e_ldn = !rst && m_flush && !m_wr && !wr_busy && m_owner == 1;
        e_ddn = !rst && m_flush && !m_wr && !wr_busy && m_owner == 2;

        s_ld_gnt = ld_burst_gnt; s_dr_gnt = dr_burst_gnt;
        s_ld_ready = ld_ready;   s_dr_ready = dr_ready;
        s_ld_done = ld_done;     s_dr_done = dr_done;
        s_wr_req = wr_req; s_wr_addr = wr_addr; s_wr_mode = wr_mode;
        s_wr_data = wr_data; s_owner = owner; s_busy = arb_busy;
        if (s_wr_req === 1'b1) n_wr++;
        if (s_ld_done === 1'b1) begin n_ldd++; done_cyc.push_back(cyc); end
        if (s_dr_done === 1'b1) begin n_drd++; done_cyc.push_back(cyc); end
        if (s_ld_gnt === 1'b1) begin grants.push_back(1); gnt_cyc.push_back(cyc); end
        if (s_dr_gnt === 1'b1) begin grants.push_back(2); gnt_cyc.push_back(cyc); n_drg++; end

        if (model_chk) begin
            chk("ld_gnt",   s_ld_gnt,   32'(win == 1));
            chk("dr_gnt",   s_dr_gnt,   32'(win == 2));
            chk("ld_ready", s_ld_ready, 32'(e_lr));
            chk("dr_ready", s_dr_ready, 32'(e_dr));
            chk("ld_done",  s_ld_done,  32'(e_ldn));
            chk("dr_done",  s_dr_done,  32'(e_ddn));
            chk("wr_req",   s_wr_req,   32'(m_wr));
            chk("wr_addr",  s_wr_addr,  m_waddr);
            chk("wr_mode",  s_wr_mode,  m_wmode);
            chk("wr_data",  s_wr_data,  m_wdata);
            chk("owner",    s_owner,    m_owner);
            chk("arb_busy", s_busy,     32'(m_owner != 0));
        end

        if (rst) begin
            m_owner = 0; m_flush = 0; m_left = 0; m_last = 2; m_wr = 0;
            m_waddr = 0; m_wmode = 0; m_wdata = 0;
        end else begin
            acc = (e_lr && ld_valid) || (e_dr && dr_valid);
            if (win == 1) begin
                m_owner = 1; m_flush = 0; m_last = 1;
                m_left = (ld_burst_len == 0) ? (1 << LEN_W) : int'(ld_burst_len);
                m_addr = int'(ld_burst_addr); m_mode = int'(ld_burst_mode);
            end else if (win == 2) begin
                m_owner = 2; m_flush = 0; m_last = 2;
                m_left = (dr_burst_len == 0) ? (1 << LEN_W) : int'(dr_burst_len);
                m_addr = int'(dr_burst_addr); m_mode = int'(dr_burst_mode);
            end else if (acc) begin
                m_waddr = m_addr; m_wmode = m_mode;
                m_wdata = e_lr ? int'(ld_data) : int'(dr_data);
                m_left--;
                if (m_left == 0) m_flush = 1;
            end else if (e_ldn || e_ddn) begin
                m_owner = 0; m_flush = 0;
            end
            m_wr = acc;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (auto_data) begin
            ld_data = 8'($urandom);
            dr_data = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ld_burst_req = 1'b0; dr_burst_req = 1'b0;
        ld_valid = 1'b0; dr_valid = 1'b0; wr_busy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (s_ld_done === 1'b1 || s_dr_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic       rst, lreq, lvalid, busy;
        logic [7:0] len, data;
        logic       e_gnt, e_rdy, e_done, e_wr;
        logic [7:0] e_wdata;
        logic [1:0] e_owner;
    } vec_t;

    localparam int NV = 14;
    vec_t tv[NV];

    function automatic vec_t mk(input int r, lq, lv, b, ln, d, g, rd, dn, w, wd, ow);
        vec_t v;
        v.rst = 1'(r); v.lreq = 1'(lq); v.lvalid = 1'(lv); v.busy = 1'(b);
        v.len = 8'(ln); v.data = 8'(d);
        v.e_gnt = 1'(g); v.e_rdy = 1'(rd); v.e_done = 1'(dn); v.e_wr = 1'(w);
        v.e_wdata = 8'(wd); v.e_owner = 2'(ow);
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ld_burst_req = 0; ld_burst_addr = 0; ld_burst_mode = 0; ld_burst_len = 0;
        dr_burst_req = 0; dr_burst_addr = 0; dr_burst_mode = 0; dr_burst_len = 0;
        ld_data = 0; dr_data = 0; ld_valid = 0; dr_valid = 0; wr_busy = 0;

        //          rst lq lv b len data  gnt rdy dn wr wdata own
        tv[0]  = mk(0, 0, 0, 0, 4, 8'h00, 0, 0, 0, 0, 8'h00, 0);  // reset state
        tv[1]  = mk(0, 1, 1, 0, 4, 8'h00, 1, 0, 0, 0, 8'h00, 0);  // cycle 0 grant
        tv[2]  = mk(0, 0, 1, 0, 4, 8'h11, 0, 1, 0, 0, 8'h00, 1);
        tv[3]  = mk(0, 0, 1, 0, 4, 8'h22, 0, 1, 0, 1, 8'h11, 1);  // first write cycle 2
        tv[4]  = mk(0, 0, 1, 0, 4, 8'h33, 0, 1, 0, 1, 8'h22, 1);
        tv[5]  = mk(0, 0, 1, 0, 4, 8'h44, 0, 1, 0, 1, 8'h33, 1);
        tv[6]  = mk(0, 1, 1, 0, 4, 8'h55, 0, 0, 0, 1, 8'h44, 1);  // flush, req ignored
        tv[7]  = mk(0, 1, 1, 0, 4, 8'h66, 0, 0, 1, 0, 8'h44, 1);  // ld_done cycle 6
        tv[8]  = mk(0, 1, 1, 0, 6, 8'h00, 1, 0, 0, 0, 8'h44, 0);  // regrant right after done
        tv[9]  = mk(0, 0, 1, 0, 6, 8'hA1, 0, 1, 0, 0, 8'h44, 1);
        tv[10] = mk(0, 0, 1, 0, 6, 8'hA2, 0, 1, 0, 1, 8'hA1, 1);
        tv[11] = mk(1, 0, 1, 0, 6, 8'hA3, 0, 0, 0, 1, 8'hA2, 1);  // reset after 2 of 6
        tv[12] = mk(0, 0, 1, 0, 6, 8'hA4, 0, 0, 0, 0, 8'h00, 0);
        tv[13] = mk(0, 0, 1, 0, 6, 8'hA5, 0, 0, 0, 0, 8'h00, 0);

        #1;
        do_reset();
        do_reset();

        // ---- directed table: load burst addr 3 mode 1, then reset abort ----
        ld_burst_addr = AW'(3);
        ld_burst_mode = 2'd1;
        for (int i = 0; i < NV; i++) begin
            rst = tv[i].rst; ld_burst_req = tv[i].lreq; ld_valid = tv[i].lvalid;
            wr_busy = tv[i].busy; ld_burst_len = tv[i].len; ld_data = tv[i].data;
            tick();
            chk($sformatf("tv%0d_ld_gnt", i),   s_ld_gnt,   tv[i].e_gnt);
            chk($sformatf("tv%0d_ld_ready", i), s_ld_ready, tv[i].e_rdy);
            chk($sformatf("tv%0d_ld_done", i),  s_ld_done,  tv[i].e_done);
            chk($sformatf("tv%0d_wr_req", i),   s_wr_req,   tv[i].e_wr);
            chk($sformatf("tv%0d_wr_data", i),  s_wr_data,  tv[i].e_wdata);
            chk($sformatf("tv%0d_owner", i),    s_owner,    tv[i].e_owner);
            chk($sformatf("tv%0d_dr_gnt", i),   s_dr_gnt,   0);
            if (tv[i].e_wr) begin
                chk($sformatf("tv%0d_wr_addr", i), s_wr_addr, 3);
                chk($sformatf("tv%0d_wr_mode", i), s_wr_mode, 1);
            end
        end

        model_chk = 1;
        auto_data = 1;

        // ---- two ties from reset: order of grants and handover timing ----
        do_reset();
        grants.delete(); gnt_cyc.delete(); done_cyc.delete();
        ld_burst_len = 2; dr_burst_len = 2; ld_burst_addr = AW'(5); dr_burst_addr = AW'(9);
        ld_burst_mode = 2'd2; dr_burst_mode = 2'd3;
        ld_valid = 1; dr_valid = 1; ld_burst_req = 1; dr_burst_req = 1;
        for (int i = 0; i < 40 && done_cyc.size() < 2; i++) begin
            tick();
            if (s_ld_gnt === 1'b1) ld_burst_req = 0;
            if (s_dr_gnt === 1'b1) dr_burst_req = 0;
        end
        chk("tie_two_done", done_cyc.size(), 2);
        if (done_cyc.size() >= 1 && gnt_cyc.size() >= 2)
            chk("tie_handover_cycle", gnt_cyc[1], done_cyc[0] + 1);
        ld_burst_req = 1; dr_burst_req = 1;
        for (int i = 0; i < 5 && grants.size() < 3; i++) tick();
        ld_burst_req = 0; dr_burst_req = 0;
        run_until_done(20, "tie2");
        chk("tie_grant_count", grants.size(), 3);
        if (grants.size() >= 3) begin
            chk("tie_grant0", grants[0], PRIO ? 2 : 1);
            chk("tie_grant1", grants[1], PRIO ? 1 : 2);
            chk("tie_grant2", grants[2], PRIO ? 2 : 1);
        end

        // ---- wr_busy stall mid-burst, len 5 ----
        n_wr = 0; n_ldd = 0;
        ld_burst_len = 5; ld_burst_addr = AW'(7); ld_valid = 1; wr_busy = 0;
        ld_burst_req = 1; tick(); ld_burst_req = 0;
        tick();
        wr_busy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_ld_ready", s_ld_ready, 0);
        end
        wr_busy = 0;
        run_until_done(20, "busy");
        chk("busy_wr_count", n_wr, 5);
        chk("busy_done_count", n_ldd, 1);

        // ---- len 0 drain burst: 256 bytes ----
        n_wr = 0; n_drd = 0;
        dr_burst_len = 0; dr_burst_addr = AW'(2); dr_valid = 1;
        dr_burst_req = 1; tick(); dr_burst_req = 0;
        run_until_done(300, "len0");
        chk("len0_wr_count", n_wr, 256);
        chk("len0_done_count", n_drd, 1);

        // ---- drain requests while a load burst is active ----
        begin
            bit seen = 0;
            ld_burst_len = 3; ld_valid = 1;
            ld_burst_req = 1; tick(); ld_burst_req = 0;
            dr_burst_req = 1; dr_burst_len = 2; dr_valid = 1;
            n_drg = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (s_ld_done === 1'b1) begin seen = 1; break; end
                chk("ovl_dr_ready_held", s_dr_ready, 0);
            end
            chk("ovl_ld_done_seen", 32'(seen), 1);
            chk("ovl_no_early_dr_gnt", n_drg, 0);
            tick();
            chk("ovl_dr_gnt_after_done", s_dr_gnt, 1);
            dr_burst_req = 0;
            run_until_done(20, "ovl_dr");
        end

        // ---- randomized traffic ----
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            ld_burst_req = ($urandom_range(0, 2) == 0);
            dr_burst_req = ($urandom_range(0, 2) == 0);
            ld_burst_len = ($urandom_range(0, 25) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            dr_burst_len = ($urandom_range(0, 25) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            ld_burst_addr = AW'($urandom); dr_burst_addr = AW'($urandom);
            ld_burst_mode = 2'($urandom); dr_burst_mode = 2'($urandom);
            ld_valid = ($urandom_range(0, 3) != 0);
            dr_valid = ($urandom_range(0, 3) != 0);
            wr_busy  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
